bg_serial_fetch_responder: RTL and testbench

BG_SERIAL_FETCH_RESPONDER -- requirements
Module: bg_serial_fetch_responder

---
 rtl/bg_pkg.sv | 24 ++
 rtl/bg_serial_fetch_responder_if.sv | 36 +++
 rtl/bg_fetch_channel.sv | 106 ++++++++++
 rtl/bg_serial_fetch_responder.sv | 73 +++++++
 tb/tb_bg_serial_fetch_responder.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bg_pkg.sv
// Shared definitions for the background-layer serial fetch responder:
// channel state encoding, default geometry and frame constants.
package bg_pkg;

  localparam int unsigned DefNLayers = 4;
  localparam int unsigned DefAddrW   = 10;
  localparam int unsigned DefDataW   = 8;

  // Value of the start bit that opens both request and response frames.
  localparam logic StartBit = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StShiftIn,
    StPending,
    StWaitMem,
    StShiftOut
  } ch_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bg_serial_fetch_responder_if.sv
// Bus bundle between the layer clients / memory and the fetch responder.
// The responder takes the slave modport; the environment takes the master modport.
interface bg_serial_fetch_responder_if
  import bg_pkg::*;
#(
  parameter int unsigned N_LAYERS = DefNLayers,
  parameter int unsigned ADDR_W   = DefAddrW,
  parameter int unsigned DATA_W   = DefDataW
) ();

  logic [N_LAYERS-1:0] addr_i;
  logic [N_LAYERS-1:0] data_o;
  logic                mem_rd_o;
  logic [ADDR_W-1:0]   mem_addr_o;
  logic [DATA_W-1:0]   mem_rdata_i;
  logic [N_LAYERS-1:0] overrun_o;

  modport slave (
    input  addr_i,
    input  mem_rdata_i,
    output data_o,
    output mem_rd_o,
    output mem_addr_o,
    output overrun_o
  );

  modport master (
    output addr_i,
    output mem_rdata_i,
    input  data_o,
    input  mem_rd_o,
    input  mem_addr_o,
    input  overrun_o
  );

endinterface

// File: rtl/bg_fetch_channel.sv
// One layer channel: deserialises a request address, waits for a grant, captures the
// memory word and serialises it back. BG_FETCH_PARITY_EN appends an even-parity bit.
module bg_fetch_channel
  import bg_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DATA_W = DefDataW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              addr_bit_i,
  input  logic              grant_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic              pending_o,
  output logic [ADDR_W-1:0] req_addr_o,
  output logic              data_o,
  output logic              overrun_o
);

`ifdef BG_FETCH_PARITY_EN
  localparam int unsigned OutW = DATA_W + 1;
`else
  localparam int unsigned OutW = DATA_W;
`endif
  localparam int unsigned CntW = $clog2(max_u(ADDR_W, OutW) + 1);

  ch_state_e         state_q;
  logic [CntW-1:0]   cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [OutW-1:0]   sh_q;
  logic              data_q;
  logic              overrun_q;
  logic              busy;

  assign busy = state_q inside {StPending, StWaitMem, StShiftOut};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      addr_q    <= '0;
      sh_q      <= '0;
      data_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      // A start bit while a request is still in flight is dropped but remembered.
      if (busy && addr_bit_i) begin
        overrun_q <= 1'b1;
      end

      case (state_q)
        StIdle: begin
          if (addr_bit_i == StartBit) begin
            state_q <= StShiftIn;
            cnt_q   <= CntW'(ADDR_W);
          end
        end

        StShiftIn: begin
          addr_q <= {addr_q[ADDR_W-2:0], addr_bit_i};
          cnt_q  <= cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            state_q <= StPending;
          end
        end

        StPending: begin
          if (grant_i) begin
            state_q <= StWaitMem;
          end
        end

        // Memory data is valid exactly one cycle after the grant.
        StWaitMem: begin
`ifdef BG_FETCH_PARITY_EN
          sh_q    <= {rdata_i, ^rdata_i};
`else
          sh_q    <= rdata_i;
`endif
          cnt_q   <= CntW'(OutW);
          data_q  <= StartBit;
          state_q <= StShiftOut;
        end

        StShiftOut: begin
          if (cnt_q == '0) begin
            data_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            data_q <= sh_q[OutW-1];
            sh_q   <= {sh_q[OutW-2:0], 1'b0};
            cnt_q  <= cnt_q - CntW'(1);
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign pending_o  = (state_q == StPending);
  assign req_addr_o = addr_q;
  assign data_o     = data_q;
  assign overrun_o  = overrun_q;

endmodule

// File: rtl/bg_serial_fetch_responder.sv
// Serves N_LAYERS serial fetch channels from one shared memory port using a
// round-robin arbiter. Optional response parity: define BG_FETCH_PARITY_EN.
module bg_serial_fetch_responder
  import bg_pkg::*;
#(
  parameter int unsigned N_LAYERS = DefNLayers,
  parameter int unsigned ADDR_W   = DefAddrW,
  parameter int unsigned DATA_W   = DefDataW
) (
  input logic                         clk,
  input logic                         rst_n,
  bg_serial_fetch_responder_if.slave  bus
);

  localparam int unsigned IdxW = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1;

  logic [N_LAYERS-1:0] pending;
  logic [N_LAYERS-1:0] grant;
  logic [ADDR_W-1:0]   ch_addr [N_LAYERS];

  logic [IdxW-1:0]     ptr_q;
  logic [IdxW-1:0]     gnt_idx;
  logic [IdxW-1:0]     cand;
  logic                gnt_valid;
  logic [ADDR_W-1:0]   last_addr_q;

  for (genvar k = 0; k < N_LAYERS; k++) begin : g_ch
    bg_fetch_channel #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .addr_bit_i (bus.addr_i[k]),
      .grant_i    (grant[k]),
      .rdata_i    (bus.mem_rdata_i),
      .pending_o  (pending[k]),
      .req_addr_o (ch_addr[k]),
      .data_o     (bus.data_o[k]),
      .overrun_o  (bus.overrun_o[k])
    );
  end

  // Search starts one past the last granted layer, wrapping round.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = ptr_q;
    cand      = '0;
    for (int unsigned i = 1; i <= N_LAYERS; i++) begin
      cand = IdxW'((32'(ptr_q) + i) % N_LAYERS);
      if (!gnt_valid && pending[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign grant = gnt_valid ? (N_LAYERS'(1) << gnt_idx) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= IdxW'(N_LAYERS - 1);
      last_addr_q <= '0;
    end else if (gnt_valid) begin
      ptr_q       <= gnt_idx;
      last_addr_q <= ch_addr[gnt_idx];
    end
  end

  assign bus.mem_rd_o   = gnt_valid;
  assign bus.mem_addr_o = gnt_valid ? ch_addr[gnt_idx] : last_addr_q;

endmodule

// File: tb/tb_bg_serial_fetch_responder.sv
// Self-checking bench for bg_serial_fetch_responder: directed vectors, corner sequences
// and random traffic scored against a memory-image reference model.
module tb_bg_serial_fetch_responder;
  import bg_pkg::*;

  localparam int unsigned NL = 4;
  localparam int unsigned AW = 10;
  localparam int unsigned DW = 8;
`ifdef BG_FETCH_PARITY_EN
  localparam int unsigned OW = DW + 1;
`else
  localparam int unsigned OW = DW;
`endif

  typedef struct {
    int            layer;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          par;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NL-1:0] addr_drv;
  logic [DW-1:0] mem_img [1 << AW];
  int            cyc = 0;
  int            n_chk = 0;
  int            n_pass = 0;
  logic          mm_rd;
  logic [AW-1:0] mm_addr;

  bg_serial_fetch_responder_if #(.N_LAYERS(NL), .ADDR_W(AW), .DATA_W(DW)) bus ();

  bg_serial_fetch_responder #(.N_LAYERS(NL), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.addr_i = addr_drv;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory: data for the address read in cycle G is presented only during G+1.
  initial begin
    bus.mem_rdata_i = '0;
    forever begin
      @(negedge clk);
      mm_rd   = bus.mem_rd_o;
      mm_addr = bus.mem_addr_o;
      @(posedge clk);
      #1;
      bus.mem_rdata_i = mm_rd ? mem_img[mm_addr] : DW'($urandom);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: no finish after %0d cycles", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // Drives start bit + address MSB first; t is the cycle of the last address bit.
  task automatic send(input int k, input logic [AW-1:0] a, output int t);
    logic [AW:0] frame;
    frame = {StartBit, a};
    for (int i = AW; i >= 0; i--) begin
      @(posedge clk);
      #1;
      addr_drv[k] = frame[i];
    end
    t = cyc;
    @(posedge clk);
    #1;
    addr_drv[k] = 1'b0;
  endtask

  task automatic rx(input int k, output int s, output logic [OW-1:0] bits, output bit ok);
    ok   = 1'b0;
    s    = -1;
    bits = '0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.data_o[k] === 1'b1) begin
        ok = 1'b1;
        s  = cyc;
        break;
      end
    end
    if (ok) begin
      for (int i = 0; i < OW; i++) begin
        @(negedge clk);
        bits = {bits[OW-2:0], bus.data_o[k]};
      end
    end
  endtask

  task automatic single(input string tag, input vec_t v);
    int t;
    int s;
    logic [OW-1:0] f;
    bit ok;
    mem_img[v.addr] = v.data;
    send(v.layer, v.addr, t);
    @(negedge clk);
    chk({tag, " rd@T+1"}, 32'(bus.mem_rd_o), 1);
    chk({tag, " addr@T+1"}, 32'(bus.mem_addr_o), 32'(v.addr));
    @(negedge clk);
    chk({tag, " rd@T+2"}, 32'(bus.mem_rd_o), 0);
    chk({tag, " addr hold"}, 32'(bus.mem_addr_o), 32'(v.addr));
    rx(v.layer, s, f, ok);
    chk({tag, " response seen"}, 32'(ok), 1);
    chk({tag, " latency"}, 32'(s - t), 3);
    chk({tag, " data"}, 32'(f[OW-1 -: DW]), 32'(v.data));
`ifdef BG_FETCH_PARITY_EN
    chk({tag, " parity"}, 32'(f[0]), 32'(v.par));
`endif
    @(negedge clk);
    chk({tag, " idle after frame"}, 32'(bus.data_o[v.layer]), 0);
  endtask

  // Reference: response equals memory image at the requested address; RR bounds wait.
  task automatic rand_layer(input int k);
    int t;
    int s;
    logic [OW-1:0] f;
    bit ok;
    logic [AW-1:0] a;
    repeat (8) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      a = AW'($urandom);
      send(k, a, t);
      rx(k, s, f, ok);
      chk($sformatf("rand L%0d response seen", k), 32'(ok), 1);
      if (ok) begin
        chk($sformatf("rand L%0d latency in 3..%0d", k, 2 + NL),
            32'((s - t >= 3) && (s - t <= 2 + int'(NL))), 1);
        chk($sformatf("rand L%0d data @%0h", k, a), 32'(f[OW-1 -: DW]), 32'(mem_img[a]));
`ifdef BG_FETCH_PARITY_EN
        chk($sformatf("rand L%0d parity", k), 32'(f[0]), 32'(^mem_img[a]));
`endif
      end
    end
  endtask

  initial begin
    vec_t          vecs [5];
    vec_t          v_rr;
    vec_t          v_rst;
    int            ts [NL];
    int            ss [NL];
    logic [OW-1:0] fs [NL];
    bit            oks [NL];
    int            t;
    int            s;
    logic [OW-1:0] f;
    bit            ok;
    bit            quiet;

    vecs[0] = '{0, 10'h2A5, 8'hC3, 1'b0};
    vecs[1] = '{1, 10'h3FF, 8'h00, 1'b0};
    vecs[2] = '{2, 10'h000, 8'hFF, 1'b0};
    vecs[3] = '{3, 10'h155, 8'hC1, 1'b1};
    vecs[4] = '{1, 10'h0F0, 8'h80, 1'b1};
    v_rr    = '{2, 10'h0AA, 8'h3C, 1'b0};
    v_rst   = '{2, 10'h100, 8'h5A, 1'b0};

    for (int i = 0; i < (1 << AW); i++) mem_img[i] = DW'($urandom);
    addr_drv = '0;
    rst_n    = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset data_o", 32'(bus.data_o), 0);
    chk("reset mem_rd_o", 32'(bus.mem_rd_o), 0);
    chk("reset mem_addr_o", 32'(bus.mem_addr_o), 0);
    chk("reset overrun_o", 32'(bus.overrun_o), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // All layers pending together straight out of reset: grants 0,1,2,3.
    fork
      send(0, 10'h001, ts[0]);
      send(1, 10'h002, ts[1]);
      send(2, 10'h003, ts[2]);
      send(3, 10'h004, ts[3]);
    join
    fork
      rx(0, ss[0], fs[0], oks[0]);
      rx(1, ss[1], fs[1], oks[1]);
      rx(2, ss[2], fs[2], oks[2]);
      rx(3, ss[3], fs[3], oks[3]);
      begin
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          chk($sformatf("simul rd@T+%0d", i + 1), 32'(bus.mem_rd_o), 1);
          chk($sformatf("simul addr@T+%0d", i + 1), 32'(bus.mem_addr_o), 32'(i + 1));
        end
      end
    join
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("simul L%0d start", k), 32'(ss[k] - ts[0]), 32'(3 + k));
      chk($sformatf("simul L%0d data", k), 32'(fs[k][OW-1 -: DW]), 32'(mem_img[k + 1]));
    end

    for (int i = 0; i < 5; i++) single($sformatf("vec%0d", i), vecs[i]);

    // Layer 2 granted last, then 1 and 3 together: 3 wins.
    single("rr L2", v_rr);
    fork
      send(1, 10'h011, ts[1]);
      send(3, 10'h033, ts[3]);
    join
    fork
      rx(1, ss[1], fs[1], oks[1]);
      rx(3, ss[3], fs[3], oks[3]);
      begin
        @(negedge clk);
        chk("rr first grant addr", 32'(bus.mem_addr_o), 32'h033);
        @(negedge clk);
        chk("rr second grant addr", 32'(bus.mem_addr_o), 32'h011);
      end
    join
    chk("rr L3 start", 32'(ss[3] - ts[3]), 3);
    chk("rr L1 start", 32'(ss[1] - ts[1]), 4);

    // Overrun during the response frame of layer 1.
    chk("overrun clear before", 32'(bus.overrun_o), 0);
    mem_img[10'h1A0] = 8'hA5;
    send(1, 10'h1A0, t);
    fork
      rx(1, s, f, ok);
      begin
        repeat (4) @(posedge clk);
        #1;
        addr_drv[1] = 1'b1;
        @(posedge clk);
        #1;
        addr_drv[1] = 1'b0;
      end
    join
    chk("overrun frame seen", 32'(ok), 1);
    chk("overrun frame latency", 32'(s - t), 3);
    chk("overrun frame data", 32'(f[OW-1 -: DW]), 32'hA5);
    chk("overrun flag set", 32'(bus.overrun_o), 32'b0010);
    repeat (5) @(negedge clk);
    chk("overrun flag held", 32'(bus.overrun_o), 32'b0010);
    chk("overrun no extra read", 32'(bus.mem_rd_o), 0);

    // Reset in the middle of layer 2's address shift.
    @(posedge clk); #1; addr_drv[2] = 1'b1;
    @(posedge clk); #1; addr_drv[2] = 1'b1;
    @(posedge clk); #1; addr_drv[2] = 1'b0;
    @(posedge clk); #1; addr_drv[2] = 1'b1;
    @(posedge clk); #1; addr_drv[2] = 1'b1;
    @(posedge clk); #1; rst_n = 1'b0; addr_drv[2] = 1'b0;
    @(negedge clk);
    chk("midreset data_o", 32'(bus.data_o), 0);
    chk("midreset mem_rd_o", 32'(bus.mem_rd_o), 0);
    chk("midreset mem_addr_o", 32'(bus.mem_addr_o), 0);
    chk("midreset overrun_o", 32'(bus.overrun_o), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    quiet = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (bus.mem_rd_o !== 1'b0 || bus.data_o !== '0) quiet = 1'b0;
    end
    chk("after reset no activity", 32'(quiet), 1);
    single("post-reset", v_rst);

    fork
      rand_layer(0);
      rand_layer(1);
      rand_layer(2);
      rand_layer(3);
    join
    chk("final overrun clear", 32'(bus.overrun_o), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
